// File: rtl/gray_wptr_gen.sv
// Write-side pointer generator for a dual-clock FIFO: binary/Gray write pointer,
// read-pointer synchronizer and decoder, registered full flag, occupancy count.
// Optional macro GRAY_WPTR_SYNC3_EN selects a 3-stage read-pointer synchronizer.
module gray_wptr_gen #(
  parameter int p_addr_width = 3,
  parameter int p_ptr_width  = p_addr_width + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push_en,
  output logic                    push_rdy,
  output logic [p_addr_width-1:0] waddr,
  output logic [p_ptr_width-1:0]  wptr_gray,
  input  logic [p_ptr_width-1:0]  rptr_gray_async,
  output logic                    full,
  output logic [p_ptr_width-1:0]  count
);

  // Top two pointer bits inverted; for a 2-bit pointer this covers both bits.
  localparam logic [p_ptr_width-1:0] c_full_mask =
    p_ptr_width'(~((32'd1 << (p_ptr_width - 2)) - 32'd1));

  logic [p_ptr_width-1:0] wbin_q, wbin_d;
  logic [p_ptr_width-1:0] wgray_q, wgray_d;
  logic [p_ptr_width-1:0] s1_q, s2_q;
  logic [p_ptr_width-1:0] rsync;
  logic [p_ptr_width-1:0] rbin_sync;
  logic                   full_q, full_d;
  logic                   push;

`ifdef GRAY_WPTR_SYNC3_EN
  logic [p_ptr_width-1:0] s3_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) s3_q <= '0;
    else       s3_q <= s2_q;
  end

  assign rsync = s3_q;
`else
  assign rsync = s2_q;
`endif

  always_comb begin
    push    = push_en && !full_q;
    wbin_d  = wbin_q + p_ptr_width'(push);
    wgray_d = wbin_d ^ (wbin_d >> 1);
    full_d  = (wgray_d == (rsync ^ c_full_mask));
  end

  always_comb begin
    rbin_sync = '0;
    rbin_sync[p_ptr_width-1] = rsync[p_ptr_width-1];
    for (int unsigned i = 0; i < p_ptr_width - 1; i++) begin
      rbin_sync[p_ptr_width-2-i] = rbin_sync[p_ptr_width-1-i] ^ rsync[p_ptr_width-2-i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      full_q  <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      s1_q    <= rptr_gray_async;
      s2_q    <= s1_q;
      full_q  <= full_d;
    end
  end

  assign wptr_gray = wgray_q;
  assign waddr     = wbin_q[p_addr_width-1:0];
  assign full      = full_q;
  assign push_rdy  = !full_q;
  assign count     = wbin_q - rbin_sync;

endmodule
